pc_ctrl: RTL and testbench
==========================

Name: pc_ctrl

Overview:
- Sequencing controller for the 10-bit program counter. Runs a fetch/execute state machine and drives the counter's PC_LD, PC_INC, PC_MUX_SEL, FROM_IMMED and FROM_STACK inputs.
- Contains a hardware return-address stack for CALL/RET and a single maskable interrupt.
- Sits between the instruction decoder and the program counter; the PC's PC_COUNT output feeds back into this block.

Parameters:
- AW, 10, address width of PC, stack entries, FROM_IMMED, FROM_STACK
- STK_DEPTH, 8, return-stack entries (power of 2, 2..32)
- INT_VECTOR, 10'h3FF, interrupt target address (PC_MUX_SEL=2 source)

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  synchronous active-low reset
- PC_COUNT  in  AW  current PC value
- IMMED  in  AW  branch/call target from instruction
- OP_JMP, OP_CALL, OP_RET, OP_RETI, OP_BRN, OP_SEI, OP_CLI  in  1 each  decoded op class, sampled in EXEC only
- COND  in  1  branch condition true (qualifies OP_BRN)
- INTR  in  1  interrupt request, level
- PC_LD  out  1  load PC from mux
- PC_INC  out  1  increment PC
- PC_MUX_SEL  out  2  0=FROM_IMMED, 1=FROM_STACK, 2=INT_VECTOR; 3 never driven
- FROM_IMMED  out  AW  equals IMMED
- FROM_STACK  out  AW  top-of-stack entry
- IR_LD  out  1  instruction register load strobe
- IE  out  1  interrupt-enable flag
- STK_EMPTY, STK_FULL  out  1 each  stack status
- STK_ERR  out  1  sticky overflow/underflow flag

Behaviour:
- Reset: RST_N=0 at a rising edge puts the block in state INIT; stack pointer=0, IE=0, STK_ERR=0. This applies mid-operation as well: any in-flight push or pop is discarded.
- While state=INIT, PC_LD, PC_INC and IR_LD are all 0. STK_EMPTY=1, STK_FULL=0.
- States and transitions:
  - INIT -> FETCH, unconditional, 1 cycle.
  - FETCH: IR_LD=1, no PC change -> EXEC.
  - EXEC: exactly one PC action is taken this cycle (see priority below). PC_LD and PC_INC are never both 1. -> INTR if an interrupt is taken, else -> FETCH.
  - INTR: push PC_COUNT (the already-updated next address), PC_LD=1, SEL=2, clear IE -> FETCH.
- EXEC priority, highest first:
  - RETI: pop, PC_LD=1, SEL=1, set IE.
  - RET: pop, PC_LD=1, SEL=1.
  - CALL: push PC_COUNT+1 (modulo 2^AW; 10'h3FF wraps to 10'h000), PC_LD=1, SEL=0.
  - JMP: PC_LD=1, SEL=0.
  - BRN with COND=1: PC_LD=1, SEL=0.
  - Otherwise: PC_INC=1. This covers BRN with COND=0 and no op asserted.
  - SEI/CLI: set/clear IE at the end of EXEC, and also PC_INC=1. They are lowest priority and are ignored if any higher op is asserted.
- Control outputs are combinational from registered state plus current inputs, so the PC updates at the edge that ends EXEC or INTR. Decode inputs are ignored outside EXEC.
- Interrupt:
  - Taken at the end of EXEC when INTR=1, IE=1 (value before this cycle's SEI/CLI/RETI update) and the stack is not full.
  - If the stack is full, the interrupt is not taken and STK_ERR is not set; it is retried on a later EXEC.
- Stack boundaries:
  - CALL when full: no push, no jump, PC_INC=1 instead, STK_ERR<=1.
  - RET/RETI when empty: no pop, PC_INC=1 instead, STK_ERR<=1. RETI still sets IE.
  - FROM_STACK is undefined-but-stable (holds the last entry) when empty.
- STK_ERR clears only on reset.
- A push and a pop never occur in the same cycle.

Optional Feature:
- Macro: PC_CTRL_INTR_EN
- Defined: interrupt logic as above.
- Undefined:
  - The INTR port remains but is ignored; the INTR state is absent.
  - IE is held at 0; OP_SEI and OP_CLI become plain PC_INC.
  - OP_RETI behaves exactly as OP_RET.
  - PC_MUX_SEL never equals 2.

Test Plan:
- Reset then idle, no ops: INIT, FETCH, EXEC... PC_INC=1 once every 2 cycles; IR_LD alternates with it; PC_LD=0 throughout.
- EXEC with OP_CALL, PC_COUNT=10'h005, IMMED=10'h040 -> PC_LD=1, SEL=0, FROM_IMMED=10'h040. Then FETCH; then EXEC with OP_RET -> SEL=1, FROM_STACK=10'h006, STK_EMPTY=1 afterwards.
- 8 nested CALLs -> STK_FULL=1. 9th CALL -> PC_INC=1, PC_LD=0, STK_ERR=1, depth stays 8. Then RST_N=0 for one edge -> STK_EMPTY=1, STK_ERR=0, IE=0.
- Branches: OP_BRN, COND=0 -> PC_INC=1; OP_BRN, COND=1, IMMED=10'h123 -> PC_LD=1, SEL=0. OP_JMP and OP_CALL together -> CALL wins, push occurs.
- SEI, then INTR=1 during a plain EXEC at PC_COUNT=10'h010 -> EXEC PC_INC, then INTR state pushes 10'h011, SEL=2, IE=0. Later RETI -> SEL=1, FROM_STACK=10'h011, IE=1. Same sequence built without PC_CTRL_INTR_EN -> no SEL=2 ever, IE stays 0.
- RET on empty stack -> PC_INC=1, STK_ERR=1. CALL at PC_COUNT=10'h3FF -> pushed value 10'h000.

Source files
------------

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch/execute sequencer for the 10-bit PC with return-address stack and maskable interrupt
// Optional feature macro: PC_CTRL_INTR_EN (interrupt logic, IE flag, INTR state, RETI sets IE)
// Ports: CLK/RST_N (sync active-low) clock and reset; PC_COUNT current PC; IMMED branch/call target;
//   OP_* decoded op class (EXEC only); COND branch condition; INTR level interrupt request;
//   PC_LD/PC_INC/PC_MUX_SEL/FROM_IMMED/FROM_STACK drive the PC; IR_LD instruction-register strobe;
//   IE interrupt enable; STK_EMPTY/STK_FULL stack status; STK_ERR sticky overflow/underflow.
module pc_ctrl #(
  parameter int AW = 10,
  parameter int STK_DEPTH = 8,
  parameter logic [AW-1:0] INT_VECTOR = 10'h3FF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [AW-1:0] PC_COUNT,
  input  logic [AW-1:0] IMMED,
  input  logic          OP_JMP,
  input  logic          OP_CALL,
  input  logic          OP_RET,
  input  logic          OP_RETI,
  input  logic          OP_BRN,
  input  logic          OP_SEI,
  input  logic          OP_CLI,
  input  logic          COND,
  input  logic          INTR,
  output logic          PC_LD,
  output logic          PC_INC,
  output logic [1:0]    PC_MUX_SEL,
  output logic [AW-1:0] FROM_IMMED,
  output logic [AW-1:0] FROM_STACK,
  output logic          IR_LD,
  output logic          IE,
  output logic          STK_EMPTY,
  output logic          STK_FULL,
  output logic          STK_ERR
);
  localparam int PW = $clog2(STK_DEPTH);
  localparam logic [PW:0] SP_FULL = (PW+1)'(STK_DEPTH);
  localparam logic [PW:0] SP_LAST = (PW+1)'(STK_DEPTH - 1);
`ifdef PC_CTRL_INTR_EN
  typedef enum logic [1:0] {S_INIT, S_FETCH, S_EXEC, S_INTR} state_t;
  logic ie_set, ie_clr, take;
`else
  typedef enum logic [1:0] {S_INIT, S_FETCH, S_EXEC} state_t;
  logic unused;
  assign unused = ^{INTR, OP_SEI, OP_CLI, INT_VECTOR};
`endif
  state_t state, nxt;
  logic [PW:0] sp;
  logic [AW-1:0] stk [STK_DEPTH];
  logic [AW-1:0] push_val;
  logic [PW-1:0] tos;
  logic push, pop, err_set;
  assign STK_EMPTY = sp == '0;
  assign STK_FULL = sp == SP_FULL;
  // when empty, FROM_STACK keeps showing entry 0, the last one popped
  assign tos = STK_EMPTY ? '0 : sp[PW-1:0] - 1'b1;
  assign FROM_STACK = stk[tos];
  assign FROM_IMMED = IMMED;
  always_comb begin
    PC_LD = 1'b0;
    PC_INC = 1'b0;
    PC_MUX_SEL = 2'd0;
    IR_LD = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    err_set = 1'b0;
    push_val = PC_COUNT + 1'b1;
    nxt = state;
`ifdef PC_CTRL_INTR_EN
    ie_set = 1'b0;
    ie_clr = 1'b0;
    take = 1'b0;
`endif
    if (state == S_INIT) nxt = S_FETCH;
    else if (state == S_FETCH) begin
      IR_LD = 1'b1;
      nxt = S_EXEC;
    end else if (state == S_EXEC) begin
      if (OP_RET | OP_RETI) begin
        pop = !STK_EMPTY;
        PC_LD = !STK_EMPTY;
        PC_INC = STK_EMPTY;
        err_set = STK_EMPTY;
        PC_MUX_SEL = 2'd1;
`ifdef PC_CTRL_INTR_EN
        ie_set = OP_RETI;
`endif
      end else if (OP_CALL) begin
        push = !STK_FULL;
        PC_LD = !STK_FULL;
        PC_INC = STK_FULL;
        err_set = STK_FULL;
      end else if (OP_JMP | (OP_BRN & COND)) PC_LD = 1'b1;
      else begin
        PC_INC = 1'b1;
`ifdef PC_CTRL_INTR_EN
        ie_set = OP_SEI;
        ie_clr = OP_CLI & !OP_SEI;
`endif
      end
`ifdef PC_CTRL_INTR_EN
      // the INTR state needs a free slot after any push made by this EXEC
      take = INTR & IE & !(STK_FULL | (push & (sp == SP_LAST)));
      nxt = take ? S_INTR : S_FETCH;
`else
      nxt = S_FETCH;
`endif
    end
`ifdef PC_CTRL_INTR_EN
    else begin
      push = 1'b1;
      push_val = PC_COUNT;
      PC_LD = 1'b1;
      PC_MUX_SEL = 2'd2;
      ie_clr = 1'b1;
      nxt = S_FETCH;
    end
`endif
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_INIT;
      sp <= '0;
      IE <= 1'b0;
      STK_ERR <= 1'b0;
    end else begin
      state <= nxt;
      if (push) begin
        stk[sp[PW-1:0]] <= push_val;
        sp <= sp + 1'b1;
      end else if (pop) sp <= sp - 1'b1;
      if (err_set) STK_ERR <= 1'b1;
`ifdef PC_CTRL_INTR_EN
      if (ie_set) IE <= 1'b1;
      else if (ie_clr) IE <= 1'b0;
`else
      IE <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed bench for pc_ctrl with a queue-based reference model checked every cycle
module tb_pc_ctrl;
  localparam int DEPTH = 8;
`ifdef PC_CTRL_INTR_EN
  localparam bit INTR_EN = 1'b1;
`else
  localparam bit INTR_EN = 1'b0;
`endif
  logic CLK = 1'b0, RST_N = 1'b0;
  logic [9:0] PC_COUNT = '0, IMMED = '0;
  logic OP_JMP = 0, OP_CALL = 0, OP_RET = 0, OP_RETI = 0, OP_BRN = 0, OP_SEI = 0, OP_CLI = 0, COND = 0, INTR = 0;
  logic PC_LD, PC_INC, IR_LD, IE, STK_EMPTY, STK_FULL, STK_ERR;
  logic [1:0] PC_MUX_SEL;
  logic [9:0] FROM_IMMED, FROM_STACK;
  int total = 0, bad = 0;
  pc_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .PC_COUNT(PC_COUNT), .IMMED(IMMED),
    .OP_JMP(OP_JMP), .OP_CALL(OP_CALL), .OP_RET(OP_RET), .OP_RETI(OP_RETI),
    .OP_BRN(OP_BRN), .OP_SEI(OP_SEI), .OP_CLI(OP_CLI), .COND(COND), .INTR(INTR),
    .PC_LD(PC_LD), .PC_INC(PC_INC), .PC_MUX_SEL(PC_MUX_SEL), .FROM_IMMED(FROM_IMMED),
    .FROM_STACK(FROM_STACK), .IR_LD(IR_LD), .IE(IE), .STK_EMPTY(STK_EMPTY),
    .STK_FULL(STK_FULL), .STK_ERR(STK_ERR)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // reference model: phase 0=init 1=fetch 2=exec 3=interrupt entry, stack as a queue
  int m_phase = 0;
  bit mvalid = 0, m_ie = 0, m_err = 0;
  int q[$];
  int n_phase, push_v;
  bit n_ie, n_err, do_push, do_pop, e_ld, e_inc, e_ir;
  int e_sel;
  always @(negedge CLK) if (mvalid) begin
    e_ld = 0; e_inc = 0; e_ir = 0; e_sel = 0; do_push = 0; do_pop = 0; push_v = 0;
    n_ie = m_ie; n_err = m_err; n_phase = m_phase;
    if (m_phase == 0) n_phase = 1;
    else if (m_phase == 1) begin
      e_ir = 1; n_phase = 2;
    end else if (m_phase == 2) begin
      if (OP_RET || OP_RETI) begin
        if (q.size() > 0) begin e_ld = 1; e_sel = 1; do_pop = 1; end
        else begin e_inc = 1; n_err = 1; end
        if (INTR_EN && OP_RETI) n_ie = 1;
      end else if (OP_CALL) begin
        if (q.size() < DEPTH) begin e_ld = 1; do_push = 1; push_v = (PC_COUNT + 1) % 1024; end
        else begin e_inc = 1; n_err = 1; end
      end else if (OP_JMP || (OP_BRN && COND)) e_ld = 1;
      else begin
        e_inc = 1;
        if (INTR_EN && OP_SEI) n_ie = 1;
        else if (INTR_EN && OP_CLI) n_ie = 0;
      end
      n_phase = (INTR_EN && INTR && m_ie && (q.size() + int'(do_push) < DEPTH)) ? 3 : 1;
    end else begin
      e_ld = 1; e_sel = 2; do_push = 1; push_v = PC_COUNT; n_ie = 0; n_phase = 1;
    end
    chk("pc_ld", PC_LD, e_ld);
    chk("pc_inc", PC_INC, e_inc);
    chk("ir_ld", IR_LD, e_ir);
    if (e_ld) chk("pc_mux_sel", PC_MUX_SEL, e_sel);
    chk("sel_legal", int'(PC_MUX_SEL == 3 || (!INTR_EN && PC_MUX_SEL == 2)), 0);
    chk("from_immed", FROM_IMMED, IMMED);
    if (q.size() > 0) chk("from_stack", FROM_STACK, q[$]);
    chk("stk_empty", STK_EMPTY, int'(q.size() == 0));
    chk("stk_full", STK_FULL, int'(q.size() == DEPTH));
    chk("ie", IE, m_ie);
    chk("stk_err", STK_ERR, m_err);
  end
  always @(posedge CLK) begin
    if (!RST_N) begin
      m_phase <= 0; m_ie <= 0; m_err <= 0; mvalid <= 1; q.delete();
    end else if (mvalid) begin
      m_phase <= n_phase; m_ie <= n_ie; m_err <= n_err;
      if (do_push) q.push_back(push_v);
      if (do_pop) void'(q.pop_back());
    end
  end
  task automatic fin();
    @(posedge CLK); #1;
    {OP_JMP, OP_CALL, OP_RET, OP_RETI, OP_BRN, OP_SEI, OP_CLI, COND, INTR} = '0;
  endtask
  task automatic go_exec();
    for (int i = 0; i < 8 && m_phase != 2; i++) fin();
    if (m_phase != 2) begin
      total++; bad++;
      $display("FAIL go_exec timeout: phase %0d expected 2", m_phase);
    end
  endtask
  task automatic do_reset();
    RST_N = 0;
    fin();
    RST_N = 1;
  endtask
  initial begin
    int n_inc, n_ir, n_ld;
    fin(); fin();
    chk("reset_empty", STK_EMPTY, 1);
    chk("reset_ir", IR_LD, 0);
    RST_N = 1;
    n_inc = 0; n_ir = 0; n_ld = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      n_inc += PC_INC; n_ir += IR_LD; n_ld += PC_LD;
      fin();
    end
    chk("idle_inc_count", n_inc, 3);
    chk("idle_ir_count", n_ir, 4);
    chk("idle_ld_count", n_ld, 0);
    go_exec();
    PC_COUNT = 10'h005; IMMED = 10'h040; OP_CALL = 1;
    @(negedge CLK);
    chk("call_ld", PC_LD, 1);
    chk("call_sel", PC_MUX_SEL, 0);
    chk("call_immed", FROM_IMMED, 10'h040);
    fin();
    go_exec();
    OP_RET = 1;
    @(negedge CLK);
    chk("ret_sel", PC_MUX_SEL, 1);
    chk("ret_stack", FROM_STACK, 10'h006);
    fin();
    chk("ret_empty", STK_EMPTY, 1);
    for (int i = 0; i < 8; i++) begin
      go_exec();
      PC_COUNT = 10'(i * 16); OP_CALL = 1;
      fin();
    end
    chk("nest_full", STK_FULL, 1);
    go_exec();
    OP_CALL = 1;
    @(negedge CLK);
    chk("ovf_inc", PC_INC, 1);
    chk("ovf_ld", PC_LD, 0);
    fin();
    chk("ovf_err", STK_ERR, 1);
    chk("ovf_full", STK_FULL, 1);
    do_reset();
    chk("rst_empty", STK_EMPTY, 1);
    chk("rst_err", STK_ERR, 0);
    chk("rst_ie", IE, 0);
    go_exec();
    OP_BRN = 1; COND = 0;
    @(negedge CLK);
    chk("brn0_inc", PC_INC, 1);
    fin();
    go_exec();
    OP_BRN = 1; COND = 1; IMMED = 10'h123;
    @(negedge CLK);
    chk("brn1_ld", PC_LD, 1);
    chk("brn1_sel", PC_MUX_SEL, 0);
    fin();
    go_exec();
    OP_JMP = 1; OP_CALL = 1; PC_COUNT = 10'h020;
    fin();
    chk("jmpcall_push", STK_EMPTY, 0);
    go_exec();
    OP_RET = 1;
    @(negedge CLK);
    chk("jmpcall_stack", FROM_STACK, 10'h021);
    fin();
    go_exec();
    OP_SEI = 1;
    fin();
    chk("sei_ie", IE, int'(INTR_EN));
    go_exec();
    INTR = 1; PC_COUNT = 10'h010;
    @(negedge CLK);
    chk("intr_exec_inc", PC_INC, 1);
    fin();
    PC_COUNT = 10'h011;
    if (INTR_EN) begin
      @(negedge CLK);
      chk("intr_ld", PC_LD, 1);
      chk("intr_sel", PC_MUX_SEL, 2);
      fin();
      chk("intr_ie", IE, 0);
    end else chk("nointr_fetch", IR_LD, 1);
    go_exec();
    OP_RETI = 1;
    @(negedge CLK);
    if (INTR_EN) begin
      chk("reti_sel", PC_MUX_SEL, 1);
      chk("reti_stack", FROM_STACK, 10'h011);
    end else chk("reti_as_ret_inc", PC_INC, 1);
    fin();
    chk("reti_ie", IE, int'(INTR_EN));
    do_reset();
    go_exec();
    OP_RET = 1;
    @(negedge CLK);
    chk("unf_inc", PC_INC, 1);
    chk("unf_ld", PC_LD, 0);
    fin();
    chk("unf_err", STK_ERR, 1);
    go_exec();
    OP_CALL = 1; PC_COUNT = 10'h3FF;
    fin();
    go_exec();
    OP_RET = 1;
    @(negedge CLK);
    chk("wrap_stack", FROM_STACK, 10'h000);
    chk("wrap_sel", PC_MUX_SEL, 1);
    fin();
    go_exec();
    OP_CALL = 1; RST_N = 0;
    fin();
    RST_N = 1;
    chk("midrst_empty", STK_EMPTY, 1);
    chk("midrst_ir", IR_LD, 0);
    fin(); fin(); fin();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
